// File: rtl/rr_dispatch_5lane.sv
// rr_dispatch_5lane
//   Round-robin work dispatcher. Incoming words are buffered in a small FIFO.
//   The head word is offered to one child lane at a time, with a valid/ready
//   handshake per lane. A lane that is disabled, or that stalls for
//   STALL_LIMIT cycles, is skipped.
//
// Ports
//   clk, rst_n    : single rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   : upstream push handshake into the FIFO
//   lane_en       : per-lane enable mask
//   out_valid     : one-hot (or zero) offer of the head word to the lane at ptr
//   out_ready     : per-lane accept; only the selected lane's bit is used
//   out_data      : FIFO head word, shared by all lanes
//   fifo_count    : current FIFO occupancy
//   dispatch_cnt  : number of words delivered, wraps at 16 bits
//   skip_pulse    : one-cycle pulse after a lane is skipped for timeout
module rr_dispatch_5lane #(
  parameter int DATA_W      = 16,
  parameter int NUM_LANES   = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [NUM_LANES-1:0]          lane_en,
  output logic [NUM_LANES-1:0]          out_valid,
  input  logic [NUM_LANES-1:0]          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   dispatch_cnt,
  output logic                          skip_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(NUM_LANES);
  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'((STALL_LIMIT == 0) ? 0 : STALL_LIMIT - 1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     ptr, next_ptr;
  logic [SW-1:0]     stall_cnt;

  logic push, pop, offer, sel_ready, xfer, timeout, advance;

  // First enabled lane after cur, scanning cyclically. Falls back to cur
  // itself when it is the only enabled lane (or when none is enabled).
  function automatic logic [LW-1:0] next_lane(input logic [LW-1:0] cur,
                                               input logic [NUM_LANES-1:0] en);
    logic [LW-1:0] res;
    logic [LW-1:0] idx;
    logic          found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      idx = LW'((int'(cur) + k) % NUM_LANES);
      if (!found && en[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    in_ready  = (fifo_count != CW'(FIFO_DEPTH));
    push      = in_valid && in_ready;
    offer     = (fifo_count != '0) && lane_en[ptr];
    sel_ready = out_ready[ptr];
    xfer      = offer && sel_ready;
    pop       = xfer;
    timeout   = (STALL_LIMIT != 0) && offer && !sel_ready && (stall_cnt == STALL_MAX);
    // A disabled current lane is left as soon as any other lane is enabled.
    advance   = xfer || timeout || (!lane_en[ptr] && (|lane_en));
    next_ptr  = next_lane(ptr, lane_en);
    out_data  = mem[rd_ptr];
    out_valid = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_valid[i] = offer && (ptr == LW'(i));
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy and the
  // pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      ptr          <= '0;
      stall_cnt    <= '0;
      dispatch_cnt <= '0;
      skip_pulse   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (xfer) dispatch_cnt <= dispatch_cnt + 16'd1;

      if (advance) ptr <= next_ptr;

      // The counter only runs while the selected lane is offered and holding
      // off; it is parked at zero otherwise, including with the FIFO empty.
      if (!offer || xfer || timeout) stall_cnt <= '0;
      else                           stall_cnt <= stall_cnt + 1'b1;

      skip_pulse <= timeout;
    end
  end

endmodule

// File: tb/tb_rr_dispatch_5lane.sv
// Testbench for rr_dispatch_5lane: directed stimulus feeds a scoreboard of
// expected (lane, word) deliveries; a negedge monitor pops and compares on
// every transfer the DUT completes.
module tb_rr_dispatch_5lane;

  localparam int DATA_W      = 16;
  localparam int NUM_LANES   = 5;
  localparam int FIFO_DEPTH  = 4;
  localparam int STALL_LIMIT = 8;

  typedef struct {
    int          lane;
    logic [15:0] data;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic [NUM_LANES-1:0] lane_en;
  logic [NUM_LANES-1:0] out_valid;
  logic [NUM_LANES-1:0] out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [2:0]           fifo_count;
  logic [15:0]          dispatch_cnt;
  logic                 skip_pulse;

  exp_t                 sb[$];
  int                   checks = 0;
  int                   errors = 0;
  logic [NUM_LANES-1:0] forbid_mask = '0;

  rr_dispatch_5lane #(
    .DATA_W      (DATA_W),
    .NUM_LANES   (NUM_LANES),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .lane_en      (lane_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .fifo_count   (fifo_count),
    .dispatch_cnt (dispatch_cnt),
    .skip_pulse   (skip_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic int lane_of(input logic [NUM_LANES-1:0] v);
    for (int i = 0; i < NUM_LANES; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] data, input int lane);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) fail_now("push_wait_timeout");
    e.lane = lane;
    e.data = data;
    sb.push_back(e);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: samples on the falling edge, where the values seen are exactly
  // the ones the next rising edge will act on.
  always @(negedge clk) begin
    exp_t e;
    int   lane;
    if (rst_n) begin
      check("out_valid_onehot", 32'($onehot0(out_valid)), 32'd1);
      if (forbid_mask != '0) check("forbidden_lane", 32'(out_valid & forbid_mask), 32'd0);
      if ((out_valid & out_ready) != '0) begin
        lane = lane_of(out_valid);
        if (sb.size() == 0) begin
          fail_now("unexpected_transfer");
          $display("  lane %0d data 0x%0h", lane, out_data);
        end else begin
          e = sb.pop_front();
          check("xfer_lane", lane, e.lane);
          check("xfer_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    lane_en   = 5'b11111;
    out_ready = 5'b11111;

    // Reset state, observed while reset is held and before any clock edge.
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_dispatch_cnt", 32'(dispatch_cnt), 32'd0);
    check("rst_skip_pulse", 32'(skip_pulse), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back stream across all lanes.
    check("t1_in_ready_0", 32'(in_ready), 32'd1);
    push_word(16'h0001, 0);
    check("t1_first_offer", 32'(out_valid), 32'b00001);
    for (int i = 2; i <= 6; i++) begin
      check("t1_in_ready", 32'(in_ready), 32'd1);
      push_word(16'(i), (i - 1) % NUM_LANES);
    end
    drain(20);
    check("t1_dispatch_cnt", 32'(dispatch_cnt), 32'd6);
    check("t1_fifo_empty", 32'(fifo_count), 32'd0);

    // Fill the FIFO with nobody ready, then free one slot.
    do_reset();
    out_ready = 5'b00000;
    push_word(16'h0010, 0);
    push_word(16'h0011, 1);
    push_word(16'h0012, 2);
    push_word(16'h0013, 3);
    check("t2_full_count", 32'(fifo_count), 32'd4);
    check("t2_full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = 16'h0014;
    tick();
    check("t2_held_count", 32'(fifo_count), 32'd4);
    check("t2_held_in_ready", 32'(in_ready), 32'd0);
    out_ready = 5'b00001;
    tick();
    check("t2_pop_count", 32'(fifo_count), 32'd3);
    check("t2_in_ready_back", 32'(in_ready), 32'd1);
    check("t2_dispatch_one", 32'(dispatch_cnt), 32'd1);
    begin
      exp_t e;
      e.lane = 4;
      e.data = 16'h0014;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    check("t2_refill_count", 32'(fifo_count), 32'd4);
    out_ready = 5'b11111;
    drain(20);
    check("t2_dispatch_cnt", 32'(dispatch_cnt), 32'd5);

    // Timeout skip: lane 0 never ready, lane 1 ready.
    do_reset();
    out_ready = 5'b00010;
    push_word(16'h00AA, 1);
    for (int i = 0; i < STALL_LIMIT; i++) begin
      check("t3_stall_offer_l0", 32'(out_valid), 32'b00001);
      check("t3_no_skip_yet", 32'(skip_pulse), 32'd0);
      tick();
    end
    check("t3_skip_pulse", 32'(skip_pulse), 32'd1);
    check("t3_offer_l1", 32'(out_valid), 32'b00010);
    tick();
    check("t3_skip_one_cycle", 32'(skip_pulse), 32'd0);
    check("t3_dispatch_cnt", 32'(dispatch_cnt), 32'd1);
    check("t3_fifo_empty", 32'(fifo_count), 32'd0);

    // Sparse enable mask: lanes 2 and 4 only.
    lane_en     = 5'b10100;
    forbid_mask = 5'b01011;
    do_reset();
    out_ready = 5'b11111;
    push_word(16'h0021, 2);
    push_word(16'h0022, 4);
    push_word(16'h0023, 2);
    drain(20);
    check("t4_dispatch_cnt", 32'(dispatch_cnt), 32'd3);
    forbid_mask = '0;
    lane_en     = 5'b11111;

    // Asynchronous reset mid-stream with three words buffered.
    do_reset();
    out_ready = 5'b11111;
    push_word(16'h0031, 0);
    drain(20);
    out_ready = 5'b00000;
    push_word(16'h0032, 1);
    push_word(16'h0033, 2);
    push_word(16'h0034, 3);
    check("t5_pre_count", 32'(fifo_count), 32'd3);
    check("t5_pre_dispatch", 32'(dispatch_cnt), 32'd1);
    check("t5_pre_offer", 32'(out_valid), 32'b00010);
    rst_n = 1'b0;
    #1;
    check("t5_async_out_valid", 32'(out_valid), 32'd0);
    check("t5_async_count", 32'(fifo_count), 32'd0);
    check("t5_async_dispatch", 32'(dispatch_cnt), 32'd0);
    check("t5_async_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 5'b11111;
    push_word(16'h0035, 0);
    drain(20);
    check("t5_post_dispatch", 32'(dispatch_cnt), 32'd1);

    // Counter wrap: 65535 transfers, then one more.
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      push_word(16'(i), i % NUM_LANES);
    end
    drain(50);
    check("t6_dispatch_ffff", 32'(dispatch_cnt), 32'h0000FFFF);
    push_word(16'hBEEF, 0);
    drain(20);
    check("t6_dispatch_wrap", 32'(dispatch_cnt), 32'd0);
    check("t6_fifo_empty", 32'(fifo_count), 32'd0);
    check("t6_no_skip", 32'(skip_pulse), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
